// File: rtl/cpu_defs.sv
// Shared CPU definitions: branch-resolution record, branch condition encoding and
// instruction size.
package cpu_defs;

    localparam int unsigned INST_BYTES = 4;

    typedef enum logic [2:0] {
        BrEq  = 3'd0,
        BrNe  = 3'd1,
        BrLt  = 3'd2,
        BrGe  = 3'd3,
        BrLtu = 3'd4,
        BrGeu = 3'd5
    } br_op_t;

    typedef struct packed {
        logic        valid;
        logic        taken;
        logic [31:0] pc;
        logic [31:0] target;
    } br_resolved_t;

    typedef enum logic {
        StIdle = 1'b0,
        StPend = 1'b1
    } br_state_t;

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch condition evaluator; unused encodings resolve as never-taken.
module br_cond_eval
    import cpu_defs::*;
(
    input  logic [2:0]  br_op,
    input  logic [31:0] rj,
    input  logic [31:0] rd,
    output logic        taken
);

    br_op_t op;
    assign op = br_op_t'(br_op);

    always_comb begin
        taken = 1'b0;
        case (op)
            BrEq:    taken = (rj == rd);
            BrNe:    taken = (rj != rd);
            BrLt:    taken = ($signed(rj) < $signed(rd));
            BrGe:    taken = ($signed(rj) >= $signed(rd));
            BrLtu:   taken = (rj < rd);
            BrGeu:   taken = (rj >= rd);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/br_resolve_unit.sv
// EX-stage branch resolution: produces the predictor training record, a held redirect
// to fetch on mispredict, a one-cycle younger-stage flush and performance counters.
module br_resolve_unit
    import cpu_defs::*;
#(
    parameter int unsigned PERF_WID = 32,
    parameter bit          PERF_EN  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    input  logic                ex_is_br,
    input  logic                ex_is_jump,
    input  logic [2:0]          ex_br_op,
    input  logic [31:0]         ex_rj,
    input  logic [31:0]         ex_rd,
    input  logic [31:0]         ex_pc,
    input  logic [31:0]         ex_target,
    input  logic                ex_pred_taken,
    input  logic [31:0]         ex_pred_npc,
    input  logic                ex_stall_in,
    output br_resolved_t        resolved_out,
    output logic                redirect_valid,
    output logic [31:0]         redirect_pc,
    input  logic                redirect_ready,
    output logic                flush_younger,
    output logic                ex_hold,
    output logic [PERF_WID-1:0] perf_br_cnt,
    output logic [PERF_WID-1:0] perf_mis_cnt
);

    br_state_t    state_q;
    br_resolved_t resolved_q;
    logic         redirect_valid_q;
    logic [31:0]  redirect_pc_q;
    logic         flush_q;

    logic        cond_taken;
    logic        fire;
    logic        taken;
    logic        mispredict;
    logic [31:0] actual_npc;

    br_cond_eval u_cond (
        .br_op (ex_br_op),
        .rj    (ex_rj),
        .rd    (ex_rd),
        .taken (cond_taken)
    );

    assign ex_hold    = (state_q == StPend);
    assign fire       = ex_valid & (ex_is_br | ex_is_jump) & ~ex_stall_in & ~ex_hold;
    assign taken      = ex_is_jump | (ex_is_br & cond_taken);
    assign actual_npc = taken ? ex_target : (ex_pc + 32'(INST_BYTES));
    // A taken prediction is only correct if fetch also steered to the right target.
    assign mispredict = (taken != ex_pred_taken) | (taken & (ex_pred_npc != ex_target));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StIdle;
            resolved_q       <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
        end else begin
            resolved_q.valid  <= fire;
            resolved_q.taken  <= taken;
            resolved_q.pc     <= ex_pc;
            resolved_q.target <= ex_target;
            flush_q           <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (fire && mispredict) begin
                        state_q          <= StPend;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= actual_npc;
                        flush_q          <= 1'b1;
                    end
                end
                StPend: begin
                    if (redirect_ready) begin
                        state_q          <= StIdle;
                        redirect_valid_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign resolved_out   = resolved_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush_younger  = flush_q;

    generate
        if (PERF_EN) begin : g_perf
            localparam logic [PERF_WID-1:0] One = {{(PERF_WID-1){1'b0}}, 1'b1};
            logic [PERF_WID-1:0] br_cnt_q;
            logic [PERF_WID-1:0] mis_cnt_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    br_cnt_q  <= '0;
                    mis_cnt_q <= '0;
                end else begin
                    if (fire) begin
                        br_cnt_q <= br_cnt_q + One;
                    end
                    if (fire && mispredict) begin
                        mis_cnt_q <= mis_cnt_q + One;
                    end
                end
            end

            assign perf_br_cnt  = br_cnt_q;
            assign perf_mis_cnt = mis_cnt_q;
        end else begin : g_no_perf
            assign perf_br_cnt  = '0;
            assign perf_mis_cnt = '0;
        end
    endgenerate

endmodule

// File: tb/tb_br_resolve_unit.sv
// Directed self-checking bench for br_resolve_unit; a narrow-counter instance shares
// the stimulus to exercise counter wrap.
module tb_br_resolve_unit;
    import cpu_defs::*;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_is_br;
    logic        ex_is_jump;
    logic [2:0]  ex_br_op;
    logic [31:0] ex_rj;
    logic [31:0] ex_rd;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_npc;
    logic        ex_stall_in;
    logic        redirect_ready;

    br_resolved_t resolved_out;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         flush_younger;
    logic         ex_hold;
    logic [31:0]  perf_br_cnt;
    logic [31:0]  perf_mis_cnt;

    br_resolved_t s_resolved_out;
    logic         s_redirect_valid;
    logic [31:0]  s_redirect_pc;
    logic         s_flush_younger;
    logic         s_ex_hold;
    logic [2:0]   s_perf_br_cnt;
    logic [2:0]   s_perf_mis_cnt;

    int checks;
    int errors;
    int exp_br;
    int exp_mis;

    br_resolve_unit dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_is_br       (ex_is_br),
        .ex_is_jump     (ex_is_jump),
        .ex_br_op       (ex_br_op),
        .ex_rj          (ex_rj),
        .ex_rd          (ex_rd),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_npc    (ex_pred_npc),
        .ex_stall_in    (ex_stall_in),
        .resolved_out   (resolved_out),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .flush_younger  (flush_younger),
        .ex_hold        (ex_hold),
        .perf_br_cnt    (perf_br_cnt),
        .perf_mis_cnt   (perf_mis_cnt)
    );

    br_resolve_unit #(.PERF_WID(3), .PERF_EN(1'b1)) dut_small (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_is_br       (ex_is_br),
        .ex_is_jump     (ex_is_jump),
        .ex_br_op       (ex_br_op),
        .ex_rj          (ex_rj),
        .ex_rd          (ex_rd),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_npc    (ex_pred_npc),
        .ex_stall_in    (ex_stall_in),
        .resolved_out   (s_resolved_out),
        .redirect_valid (s_redirect_valid),
        .redirect_pc    (s_redirect_pc),
        .redirect_ready (redirect_ready),
        .flush_younger  (s_flush_younger),
        .ex_hold        (s_ex_hold),
        .perf_br_cnt    (s_perf_br_cnt),
        .perf_mis_cnt   (s_perf_mis_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_br(input logic br, input logic jmp, input logic [2:0] op,
                            input logic [31:0] rj, input logic [31:0] rd,
                            input logic [31:0] pc, input logic [31:0] tgt,
                            input logic pt, input logic [31:0] pnpc);
        ex_valid      = 1'b1;
        ex_is_br      = br;
        ex_is_jump    = jmp;
        ex_br_op      = op;
        ex_rj         = rj;
        ex_rd         = rd;
        ex_pc         = pc;
        ex_target     = tgt;
        ex_pred_taken = pt;
        ex_pred_npc   = pnpc;
    endtask

    task automatic clear_ex();
        ex_valid   = 1'b0;
        ex_is_br   = 1'b0;
        ex_is_jump = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_ex();
        ex_stall_in    = 1'b0;
        redirect_ready = 1'b0;
        ex_br_op = 3'd0; ex_rj = '0; ex_rd = '0; ex_pc = '0; ex_target = '0;
        ex_pred_taken = 1'b0; ex_pred_npc = '0;
        tick();
        tick();
        checks++; if (resolved_out.valid !== 1'b0) begin
            $display("FAIL reset_resolved: got %b want 0", resolved_out.valid); errors++; end
        checks++; if (redirect_valid !== 1'b0 || flush_younger !== 1'b0 || ex_hold !== 1'b0) begin
            $display("FAIL reset_ctrl: got rv=%b fl=%b hold=%b want 0/0/0",
                     redirect_valid, flush_younger, ex_hold); errors++; end
        checks++; if (perf_br_cnt !== 32'd0 || perf_mis_cnt !== 32'd0) begin
            $display("FAIL reset_cnt: got %0d/%0d want 0/0", perf_br_cnt, perf_mis_cnt); errors++; end
        rst = 1'b0;
        tick();
        exp_br = 0;
        exp_mis = 0;
    endtask

    task automatic test_beq_correct();
        drive_br(1'b1, 1'b0, 3'd0, 32'd5, 32'd5, 32'h1C000010, 32'h1C000040, 1'b1, 32'h1C000040);
        tick();
        clear_ex();
        exp_br++;
        checks++; if (resolved_out !== {1'b1, 1'b1, 32'h1C000010, 32'h1C000040}) begin
            $display("FAIL beq_resolved: got %h want %h", resolved_out,
                     {1'b1, 1'b1, 32'h1C000010, 32'h1C000040}); errors++; end
        checks++; if (redirect_valid !== 1'b0 || flush_younger !== 1'b0) begin
            $display("FAIL beq_no_redirect: got rv=%b fl=%b want 0/0",
                     redirect_valid, flush_younger); errors++; end
        checks++; if (perf_br_cnt !== 32'(exp_br) || perf_mis_cnt !== 32'(exp_mis)) begin
            $display("FAIL beq_cnt: got %0d/%0d want %0d/%0d", perf_br_cnt, perf_mis_cnt,
                     exp_br, exp_mis); errors++; end
        tick();
        checks++; if (resolved_out.valid !== 1'b0) begin
            $display("FAIL beq_pulse: got valid=%b want 0", resolved_out.valid); errors++; end
    endtask

    task automatic test_blt_bltu();
        drive_br(1'b1, 1'b0, 3'd2, 32'hFFFFFFFF, 32'd1, 32'h1C000020, 32'h1C000100, 1'b0,
                 32'h1C000024);
        tick();
        clear_ex();
        exp_br++; exp_mis++;
        checks++; if (resolved_out !== {1'b1, 1'b1, 32'h1C000020, 32'h1C000100}) begin
            $display("FAIL blt_resolved: got %h want taken record", resolved_out); errors++; end
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1C000100) begin
            $display("FAIL blt_redirect: got rv=%b pc=%h want 1/1c000100",
                     redirect_valid, redirect_pc); errors++; end
        checks++; if (flush_younger !== 1'b1 || ex_hold !== 1'b1) begin
            $display("FAIL blt_flush: got fl=%b hold=%b want 1/1", flush_younger, ex_hold);
            errors++; end
        checks++; if (perf_mis_cnt !== 32'(exp_mis)) begin
            $display("FAIL blt_mis_cnt: got %0d want %0d", perf_mis_cnt, exp_mis); errors++; end
        tick();
        checks++; if (flush_younger !== 1'b0 || redirect_valid !== 1'b1) begin
            $display("FAIL blt_flush_pulse: got fl=%b rv=%b want 0/1", flush_younger,
                     redirect_valid); errors++; end
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        checks++; if (redirect_valid !== 1'b0 || ex_hold !== 1'b0) begin
            $display("FAIL blt_handshake: got rv=%b hold=%b want 0/0", redirect_valid, ex_hold);
            errors++; end
        drive_br(1'b1, 1'b0, 3'd4, 32'hFFFFFFFF, 32'd1, 32'h1C000020, 32'h1C000100, 1'b0,
                 32'h1C000024);
        tick();
        clear_ex();
        exp_br++;
        checks++; if (resolved_out.valid !== 1'b1 || resolved_out.taken !== 1'b0) begin
            $display("FAIL bltu_resolved: got v=%b t=%b want 1/0", resolved_out.valid,
                     resolved_out.taken); errors++; end
        checks++; if (redirect_valid !== 1'b0 || flush_younger !== 1'b0) begin
            $display("FAIL bltu_no_redirect: got rv=%b fl=%b want 0/0", redirect_valid,
                     flush_younger); errors++; end
        checks++; if (perf_br_cnt !== 32'(exp_br) || perf_mis_cnt !== 32'(exp_mis)) begin
            $display("FAIL bltu_cnt: got %0d/%0d want %0d/%0d", perf_br_cnt, perf_mis_cnt,
                     exp_br, exp_mis); errors++; end
        tick();
    endtask

    task automatic test_unused_op();
        drive_br(1'b1, 1'b0, 3'd6, 32'd7, 32'd7, 32'h00001000, 32'h00002000, 1'b0, 32'h00001004);
        tick();
        clear_ex();
        exp_br++;
        checks++; if (resolved_out.valid !== 1'b1 || resolved_out.taken !== 1'b0
                      || redirect_valid !== 1'b0) begin
            $display("FAIL op6_never_taken: got v=%b t=%b rv=%b want 1/0/0", resolved_out.valid,
                     resolved_out.taken, redirect_valid); errors++; end
        tick();
    endtask

    task automatic test_hold();
        drive_br(1'b1, 1'b0, 3'd1, 32'd1, 32'd2, 32'h00002000, 32'h00003000, 1'b0, 32'h00002004);
        tick();
        exp_br++; exp_mis++;
        for (int i = 1; i <= 4; i++) begin
            checks++; if (ex_hold !== 1'b1 || redirect_valid !== 1'b1
                          || redirect_pc !== 32'h00003000) begin
                $display("FAIL hold_cycle%0d: got hold=%b rv=%b pc=%h want 1/1/00003000", i,
                         ex_hold, redirect_valid, redirect_pc); errors++; end
            checks++; if (flush_younger !== (i == 1) || resolved_out.valid !== (i == 1)) begin
                $display("FAIL hold_pulse%0d: got fl=%b v=%b want %0d/%0d", i, flush_younger,
                         resolved_out.valid, (i == 1), (i == 1)); errors++; end
            if (i == 1) begin
                drive_br(1'b1, 1'b0, 3'd0, 32'd3, 32'd3, 32'h00002100, 32'h00002200, 1'b1,
                         32'h00002200);
            end
            if (i == 4) begin
                redirect_ready = 1'b1;
                clear_ex();
            end
            tick();
        end
        redirect_ready = 1'b0;
        checks++; if (ex_hold !== 1'b0 || redirect_valid !== 1'b0 || resolved_out.valid !== 1'b0)
        begin
            $display("FAIL hold_release: got hold=%b rv=%b v=%b want 0/0/0", ex_hold,
                     redirect_valid, resolved_out.valid); errors++; end
        checks++; if (perf_br_cnt !== 32'(exp_br) || perf_mis_cnt !== 32'(exp_mis)) begin
            $display("FAIL hold_cnt: got %0d/%0d want %0d/%0d", perf_br_cnt, perf_mis_cnt,
                     exp_br, exp_mis); errors++; end
    endtask

    task automatic test_jump();
        // Branch condition is false but the jump flag must win.
        drive_br(1'b1, 1'b1, 3'd0, 32'd1, 32'd2, 32'h00000080, 32'h00000200, 1'b1, 32'h00000100);
        tick();
        clear_ex();
        exp_br++; exp_mis++;
        checks++; if (resolved_out !== {1'b1, 1'b1, 32'h00000080, 32'h00000200}) begin
            $display("FAIL jump_resolved: got %h want taken record", resolved_out); errors++; end
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h00000200) begin
            $display("FAIL jump_redirect: got rv=%b pc=%h want 1/00000200", redirect_valid,
                     redirect_pc); errors++; end
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        checks++; if (redirect_valid !== 1'b0 || ex_hold !== 1'b0) begin
            $display("FAIL jump_handshake: got rv=%b hold=%b want 0/0", redirect_valid, ex_hold);
            errors++; end
    endtask

    task automatic test_stall();
        drive_br(1'b1, 1'b0, 3'd0, 32'd4, 32'd4, 32'h00004000, 32'h00004400, 1'b1, 32'h00004400);
        ex_stall_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (resolved_out.valid !== 1'b0 || perf_br_cnt !== 32'(exp_br)) begin
                $display("FAIL stall_hold%0d: got v=%b cnt=%0d want 0/%0d", i, resolved_out.valid,
                         perf_br_cnt, exp_br); errors++; end
        end
        ex_stall_in = 1'b0;
        tick();
        clear_ex();
        exp_br++;
        checks++; if (resolved_out.valid !== 1'b1 || perf_br_cnt !== 32'(exp_br)) begin
            $display("FAIL stall_fire: got v=%b cnt=%0d want 1/%0d", resolved_out.valid,
                     perf_br_cnt, exp_br); errors++; end
        tick();
        checks++; if (resolved_out.valid !== 1'b0 || perf_br_cnt !== 32'(exp_br)) begin
            $display("FAIL stall_once: got v=%b cnt=%0d want 0/%0d", resolved_out.valid,
                     perf_br_cnt, exp_br); errors++; end
    endtask

    task automatic test_pc_wrap();
        drive_br(1'b1, 1'b0, 3'd1, 32'd9, 32'd9, 32'hFFFFFFFC, 32'h00000040, 1'b1, 32'h00000040);
        tick();
        clear_ex();
        exp_br++; exp_mis++;
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h00000000
                      || resolved_out.taken !== 1'b0) begin
            $display("FAIL pc_wrap: got rv=%b pc=%h t=%b want 1/00000000/0", redirect_valid,
                     redirect_pc, resolved_out.taken); errors++; end
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
    endtask

    task automatic test_reset_mid_pend();
        drive_br(1'b1, 1'b0, 3'd0, 32'd1, 32'd2, 32'h00005000, 32'h00005800, 1'b1, 32'h00005800);
        tick();
        clear_ex();
        checks++; if (redirect_valid !== 1'b1 || ex_hold !== 1'b1) begin
            $display("FAIL pend_entry: got rv=%b hold=%b want 1/1", redirect_valid, ex_hold);
            errors++; end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (redirect_valid !== 1'b0 || ex_hold !== 1'b0 || flush_younger !== 1'b0
                      || resolved_out.valid !== 1'b0) begin
            $display("FAIL async_rst_ctrl: got rv=%b hold=%b fl=%b v=%b want 0/0/0/0",
                     redirect_valid, ex_hold, flush_younger, resolved_out.valid); errors++; end
        checks++; if (perf_br_cnt !== 32'd0 || perf_mis_cnt !== 32'd0) begin
            $display("FAIL async_rst_cnt: got %0d/%0d want 0/0", perf_br_cnt, perf_mis_cnt);
            errors++; end
        tick();
        rst = 1'b0;
        exp_br = 0; exp_mis = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (flush_younger !== 1'b0 || resolved_out.valid !== 1'b0
                          || redirect_valid !== 1'b0) begin
                $display("FAIL post_rst%0d: got fl=%b v=%b rv=%b want 0/0/0", i, flush_younger,
                         resolved_out.valid, redirect_valid); errors++; end
        end
    endtask

    task automatic test_counter_wrap();
        drive_br(1'b1, 1'b0, 3'd0, 32'd6, 32'd6, 32'h00006000, 32'h00006100, 1'b1, 32'h00006100);
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 7) begin
                checks++; if (s_perf_br_cnt !== 3'd7) begin
                    $display("FAIL wrap_br_top: got %0d want 7", s_perf_br_cnt); errors++; end
            end
        end
        exp_br += 8;
        checks++; if (s_perf_br_cnt !== 3'd0 || perf_br_cnt !== 32'(exp_br)) begin
            $display("FAIL wrap_br: got small=%0d main=%0d want 0/%0d", s_perf_br_cnt,
                     perf_br_cnt, exp_br); errors++; end
        // Mispredict every other cycle: fire, then one PEND cycle with ready held high.
        drive_br(1'b1, 1'b0, 3'd1, 32'd6, 32'd6, 32'h00006000, 32'h00006100, 1'b1, 32'h00006100);
        redirect_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
        end
        clear_ex();
        redirect_ready = 1'b0;
        exp_br += 8; exp_mis += 8;
        checks++; if (s_perf_mis_cnt !== 3'd0 || perf_mis_cnt !== 32'(exp_mis)) begin
            $display("FAIL wrap_mis: got small=%0d main=%0d want 0/%0d", s_perf_mis_cnt,
                     perf_mis_cnt, exp_mis); errors++; end
        checks++; if (s_perf_br_cnt !== 3'(exp_br) || perf_br_cnt !== 32'(exp_br)) begin
            $display("FAIL wrap_br_total: got small=%0d main=%0d want %0d/%0d", s_perf_br_cnt,
                     perf_br_cnt, exp_br % 8, exp_br); errors++; end
        tick();
        checks++; if (ex_hold !== 1'b0 || redirect_valid !== 1'b0) begin
            $display("FAIL wrap_idle: got hold=%b rv=%b want 0/0", ex_hold, redirect_valid);
            errors++; end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_br = 0;
        exp_mis = 0;
        test_reset();
        test_beq_correct();
        test_blt_bltu();
        test_unused_op();
        test_hold();
        test_jump();
        test_stall();
        test_pc_wrap();
        test_reset_mid_pend();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/br_resolve_unit.md
Name: br_resolve_unit

Overview:
- Sits in the EX stage and is the producer of br_resolved_t, the branch-resolution record consumed by the fetch-side predictor for GHR, PHT and BTB training.
- Evaluates conditional branches and jumps, compares the actual outcome with the prediction carried down the pipe, and issues a held redirect to fetch on a mispredict.
- Flushes younger stages on a mispredict and keeps branch and mispredict performance counters.

Parameters:
- PERF_WID, 32, width of the performance counters.
- PERF_EN, 1, when 0 the counters are tied to 0.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ex_valid  in  1  EX holds a valid instruction
- ex_is_br  in  1  conditional branch
- ex_is_jump  in  1  unconditional jump (direct or indirect)
- ex_br_op  in  3  condition: 0 beq, 1 bne, 2 blt, 3 bge, 4 bltu, 5 bgeu; 6/7 treated as never-taken
- ex_rj  in  32  first operand
- ex_rd  in  32  second operand
- ex_pc  in  32  instruction PC
- ex_target  in  32  computed taken target
- ex_pred_taken  in  1  fetch predicted taken
- ex_pred_npc  in  32  fetch-predicted next PC
- ex_stall_in  in  1  EX is not advancing this cycle
- resolved_out  out  66  br_resolved_t {valid, taken, pc, target}
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  32  correct next PC
- redirect_ready  in  1  fetch accepts the redirect
- flush_younger  out  1  flush IF1/IF2/ID
- ex_hold  out  1  stall EX while a redirect is pending
- perf_br_cnt  out  PERF_WID  number of resolved branches and jumps
- perf_mis_cnt  out  PERF_WID  number of mispredicts

Behaviour:
- Reset: all outputs 0, both counters 0, FSM in IDLE. A reset while in PEND drops the redirect immediately; no flush is issued afterwards.
- fire = ex_valid & (ex_is_br | ex_is_jump) & ~ex_stall_in & ~ex_hold.
- taken:
  - = 1 when ex_is_jump.
  - Otherwise evaluated per ex_br_op; blt/bge are signed compares, bltu/bgeu unsigned.
  - If ex_is_br and ex_is_jump are both set, jump wins.
- actual_npc = taken ? ex_target : ex_pc + 32'd4, with 32-bit wrap (PC 0xFFFFFFFC gives 0x0).
- mispredict = (taken != ex_pred_taken) | (taken & (ex_pred_npc != ex_target)).
- resolved_out:
  - Registered, latency 1: a fire in cycle N gives valid=1 in N+1 with the fire-cycle taken, pc and target.
  - Single-cycle pulse; valid=0 otherwise. Other fields are don't-care when valid=0.
  - Emitted for every fire, correct or not.
- FSM, IDLE -> PEND:
  - Taken on fire & mispredict in cycle N.
  - In N+1: redirect_valid=1, redirect_pc=actual_npc, flush_younger=1 for exactly that one cycle.
- FSM, PEND:
  - redirect_valid and redirect_pc stay stable until redirect_ready.
  - ex_hold=1, so no new fire occurs.
  - In the cycle redirect_ready=1: handshake completes and the next state is IDLE. ex_hold falls in the next cycle.
- redirect_ready in IDLE is ignored.
- ex_hold is combinational from state (state==PEND) only; there is no combinational path from ex_* inputs to any output.
- Counters (registered, same cycle as resolved_out valid):
  - perf_br_cnt += 1 per fire.
  - perf_mis_cnt += 1 per mispredict fire.
  - Both wrap from all-ones to 0.
- A stalled EX (ex_stall_in=1) never fires, so a branch held in EX is resolved exactly once.

Decomposition:
- Shared cpu_defs package: br_resolved_t (valid, taken, pc, target), br_op_t enum, INST_BYTES=4.
- One natural sub-module, br_cond_eval: purely combinational; ex_br_op, ex_rj and ex_rd in, taken out.
- FSM, registers and counters stay in br_resolve_unit.

Test Plan:
- beq, rj=rd=5, pred_taken=1, pred_npc=target=0x1C000040, pc=0x1C000010 -> next cycle resolved_out={1,1,0x1C000010,0x1C000040}; redirect_valid=0; perf_br_cnt=1, perf_mis_cnt=0.
- blt, rj=0xFFFFFFFF, rd=1, pred_taken=0 -> signed taken; redirect_pc=target; flush_younger pulses 1 cycle; perf_mis_cnt=1. Same case with bltu -> not taken, no redirect.
- Mispredict with redirect_ready held 0 for 3 cycles -> redirect_valid/pc stable, ex_hold=1 for 4 cycles, branches presented in EX do not fire. Ready=1 on the 4th cycle -> IDLE and ex_hold=0 the following cycle.
- Jump, pred_taken=1, pred_npc=0x100, target=0x200 -> mispredict (target mismatch), redirect_pc=0x200.
- Branch with ex_stall_in=1 for 2 cycles, then 0 -> exactly one resolved_out pulse; perf_br_cnt increments by 1.
- rst asserted mid-PEND -> redirect_valid, ex_hold and counters drop to 0 immediately; after release no flush and no resolved pulse. Counter preloaded near all-ones (force) -> wraps to 0.
